// File: rtl/keypad_entry_if.sv
// Scanner-to-entry bus: per-frame scan result in, debounced key events and entry buffer out.
// master = scanner/consumer side, slave = keypad_entry.
interface keypad_entry_if;
   logic        scan_valid;
   logic        key_hit;
   logic [3:0]  key_code;
   logic        key_event;
   logic [3:0]  key_out;
   logic        key_held;
   logic [15:0] digits;
   logic [2:0]  digit_count;

   modport master (
      output scan_valid,
      output key_hit,
      output key_code,
      input  key_event,
      input  key_out,
      input  key_held,
      input  digits,
      input  digit_count
   );

   modport slave (
      input  scan_valid,
      input  key_hit,
      input  key_code,
      output key_event,
      output key_out,
      output key_held,
      output digits,
      output digit_count
   );
endinterface

// File: rtl/keypad_entry.sv
// keypad_entry: debounces keypad scan frames into single key events and keeps a 4-digit hex entry buffer.
// Define KEY_REPEAT_EN to enable auto-repeat while a key stays held.
module keypad_entry #(
   parameter int STABLE_FRAMES = 4,
   parameter int REPEAT_DELAY  = 100,
   parameter int REPEAT_RATE   = 25
) (
   input  logic          clk,
   input  logic          clr_n,
   keypad_entry_if.slave kp
);

   localparam bit PARAMS_OK = (STABLE_FRAMES >= 1) && (STABLE_FRAMES <= 15) &&
                              (REPEAT_DELAY >= 1) && (REPEAT_DELAY <= 255) &&
                              (REPEAT_RATE >= 1) && (REPEAT_RATE <= 255);

   generate
      if (!PARAMS_OK) begin : g_bad_params
         $error("keypad_entry: parameter out of legal range");
      end
   endgenerate

   localparam logic [3:0] STABLE_LAST = 4'(STABLE_FRAMES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRESS = 2'd1,
      HELD  = 2'd2,
      REL   = 2'd3
   } state_t;

   state_t     state;
   logic [3:0] cand;
   logic [3:0] cnt;

`ifdef KEY_REPEAT_EN
   localparam logic [7:0] DELAY_T = 8'(REPEAT_DELAY);
   localparam logic [7:0] RATE_T  = 8'(REPEAT_RATE);

   logic [7:0] rpt;
   logic       rpt_first;
   logic [7:0] rpt_next;
   logic [7:0] rpt_target;

   assign rpt_next   = rpt + 8'd1;
   assign rpt_target = rpt_first ? DELAY_T : RATE_T;
`endif

   // Digit keys shift in at the low end; backspace drops the newest digit.
   function automatic logic [15:0] next_digits(input logic [3:0]  code,
                                               input logic [15:0] d,
                                               input logic [2:0]  n);
      next_digits = d;
      if (code <= 4'h9) begin
         next_digits = {d[11:0], code};
      end else if (code == 4'hE) begin
         if (n != 3'd0) begin
            next_digits = {4'h0, d[15:4]};
         end
      end else if (code == 4'hF) begin
         next_digits = 16'h0000;
      end
   endfunction

   function automatic logic [2:0] next_count(input logic [3:0] code,
                                             input logic [2:0] n);
      next_count = n;
      if (code <= 4'h9) begin
         next_count = (n == 3'd4) ? 3'd4 : n + 3'd1;
      end else if (code == 4'hE) begin
         next_count = (n == 3'd0) ? 3'd0 : n - 3'd1;
      end else if (code == 4'hF) begin
         next_count = 3'd0;
      end
   endfunction

   // Debounce FSM; every event site applies the same buffer update so outputs move together.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state          <= IDLE;
         cand           <= 4'h0;
         cnt            <= 4'h0;
         kp.key_event   <= 1'b0;
         kp.key_out     <= 4'h0;
         kp.key_held    <= 1'b0;
         kp.digits      <= 16'h0000;
         kp.digit_count <= 3'd0;
`ifdef KEY_REPEAT_EN
         rpt            <= 8'd0;
         rpt_first      <= 1'b1;
`endif
      end else begin
         kp.key_event <= 1'b0;
         if (kp.scan_valid) begin
            case (state)
               IDLE: begin
                  if (kp.key_hit) begin
                     cand <= kp.key_code;
                     if (STABLE_FRAMES == 1) begin
                        state          <= HELD;
                        cnt            <= 4'h0;
                        kp.key_event   <= 1'b1;
                        kp.key_out     <= kp.key_code;
                        kp.key_held    <= 1'b1;
                        kp.digits      <= next_digits(kp.key_code, kp.digits, kp.digit_count);
                        kp.digit_count <= next_count(kp.key_code, kp.digit_count);
`ifdef KEY_REPEAT_EN
                        rpt            <= 8'd0;
                        rpt_first      <= 1'b1;
`endif
                     end else begin
                        state <= PRESS;
                        cnt   <= 4'h1;
                     end
                  end
               end

               PRESS: begin
                  if (kp.key_hit && (kp.key_code == cand)) begin
                     if (cnt == STABLE_LAST) begin
                        state          <= HELD;
                        cnt            <= 4'h0;
                        kp.key_event   <= 1'b1;
                        kp.key_out     <= cand;
                        kp.key_held    <= 1'b1;
                        kp.digits      <= next_digits(cand, kp.digits, kp.digit_count);
                        kp.digit_count <= next_count(cand, kp.digit_count);
`ifdef KEY_REPEAT_EN
                        rpt            <= 8'd0;
                        rpt_first      <= 1'b1;
`endif
                     end else begin
                        cnt <= cnt + 4'h1;
                     end
                  end else begin
                     state <= IDLE;
                     cnt   <= 4'h0;
                  end
               end

               // A different code while held is ignored: no rollover to a second key.
               HELD: begin
                  if (!kp.key_hit) begin
                     if (STABLE_FRAMES == 1) begin
                        state       <= IDLE;
                        cnt         <= 4'h0;
                        kp.key_held <= 1'b0;
                     end else begin
                        state <= REL;
                        cnt   <= 4'h1;
                     end
                  end
`ifdef KEY_REPEAT_EN
                  else if (kp.key_code == cand) begin
                     if (rpt_next == rpt_target) begin
                        rpt            <= 8'd0;
                        rpt_first      <= 1'b0;
                        kp.key_event   <= 1'b1;
                        kp.key_out     <= cand;
                        kp.digits      <= next_digits(cand, kp.digits, kp.digit_count);
                        kp.digit_count <= next_count(cand, kp.digit_count);
                     end else begin
                        rpt <= rpt_next;
                     end
                  end
`endif
               end

               REL: begin
                  if (kp.key_hit) begin
                     state <= HELD;
                     cnt   <= 4'h0;
`ifdef KEY_REPEAT_EN
                     rpt       <= 8'd0;
                     rpt_first <= 1'b1;
`endif
                  end else if (cnt == STABLE_LAST) begin
                     state       <= IDLE;
                     cnt         <= 4'h0;
                     kp.key_held <= 1'b0;
                  end else begin
                     cnt <= cnt + 4'h1;
                  end
               end

               default: begin
                  state <= IDLE;
                  cnt   <= 4'h0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: directed and randomized frame sequences for keypad_entry, checked against a frame-level model.
// Honours KEY_REPEAT_EN the same way as the design.
module tb_keypad_entry;

   localparam int STABLE = 4;
   localparam int DELAY  = 5;
   localparam int RATE   = 2;

   logic clk = 1'b0;
   logic clr_n;

   always #5 clk = ~clk;

   keypad_entry_if kp_bus ();

   keypad_entry #(
      .STABLE_FRAMES (STABLE),
      .REPEAT_DELAY  (DELAY),
      .REPEAT_RATE   (RATE)
   ) dut (
      .clk   (clk),
      .clr_n (clr_n),
      .kp    (kp_bus)
   );

   int n_cmp  = 0;
   int n_fail = 0;
   int obs_events = 0;

   // Model: key down/up flag, supporting-frame run lengths, and the buffer as a list of digits.
   bit         m_down;
   int         m_run;
   int         m_rel;
   logic [3:0] m_key;
   int         m_rep;
   bit         m_rep_first;
   int         buf_q[$];
   logic       e_event;
   logic [3:0] e_out;
   logic       e_held;

   function automatic logic [15:0] exp_digits();
      logic [15:0] r = 16'h0000;
      for (int i = 0; i < buf_q.size(); i++) begin
         r = r | (16'(buf_q[buf_q.size() - 1 - i]) << (4 * i));
      end
      return r;
   endfunction

   task automatic model_reset();
      m_down = 0; m_run = 0; m_rel = 0; m_key = 4'h0;
      m_rep = 0; m_rep_first = 1;
      buf_q.delete();
      e_event = 1'b0; e_out = 4'h0; e_held = 1'b0;
   endtask

   task automatic do_event(input logic [3:0] c);
      e_event = 1'b1;
      e_out   = c;
      if (c <= 4'h9) begin
         buf_q.push_back(int'(c));
         if (buf_q.size() > 4) void'(buf_q.pop_front());
      end else if (c == 4'hE) begin
         if (buf_q.size() > 0) void'(buf_q.pop_back());
      end else if (c == 4'hF) begin
         buf_q.delete();
      end
   endtask

   task automatic model_frame(input bit hit, input logic [3:0] code);
      e_event = 1'b0;
      if (!m_down) begin
         if (hit && m_run > 0 && code == m_key) m_run++;
         else if (hit && m_run == 0) begin m_key = code; m_run = 1; end
         else m_run = 0;
         if (m_run == STABLE) begin
            m_down = 1; m_run = 0; m_rel = 0; m_rep = 0; m_rep_first = 1;
            do_event(m_key);
         end
      end else if (!hit) begin
         m_rel++;
         if (m_rel == STABLE) begin m_down = 0; m_rel = 0; end
      end else if (m_rel > 0) begin
         m_rel = 0; m_rep = 0; m_rep_first = 1;
      end
`ifdef KEY_REPEAT_EN
      else if (code == m_key) begin
         m_rep++;
         if (m_rep == (m_rep_first ? DELAY : RATE)) begin
            m_rep = 0; m_rep_first = 0;
            do_event(m_key);
         end
      end
`endif
      e_held = m_down;
   endtask

   task automatic check_output(input string tag);
      n_cmp++;
      assert (kp_bus.key_event === e_event) else begin
         n_fail++;
         $error("[TB] FAIL %s key_event: observed %0b expected %0b", tag, kp_bus.key_event, e_event);
      end
      n_cmp++;
      assert (kp_bus.key_out === e_out) else begin
         n_fail++;
         $error("[TB] FAIL %s key_out: observed %0h expected %0h", tag, kp_bus.key_out, e_out);
      end
      n_cmp++;
      assert (kp_bus.key_held === e_held) else begin
         n_fail++;
         $error("[TB] FAIL %s key_held: observed %0b expected %0b", tag, kp_bus.key_held, e_held);
      end
      n_cmp++;
      assert (kp_bus.digits === exp_digits()) else begin
         n_fail++;
         $error("[TB] FAIL %s digits: observed %h expected %h", tag, kp_bus.digits, exp_digits());
      end
      n_cmp++;
      assert (kp_bus.digit_count === 3'(buf_q.size())) else begin
         n_fail++;
         $error("[TB] FAIL %s digit_count: observed %0d expected %0d", tag, kp_bus.digit_count, buf_q.size());
      end
   endtask

   task automatic check_const(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      n_cmp++;
      assert (observed === expected) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // One clock cycle: drive at negedge, model the sampling edge, compare at the next negedge.
   task automatic apply_stimulus(input bit sv, input bit hit, input logic [3:0] code);
      kp_bus.scan_valid = sv;
      kp_bus.key_hit    = hit;
      kp_bus.key_code   = code;
      @(posedge clk);
      if (sv) model_frame(hit, code);
      else e_event = 1'b0;
      @(negedge clk);
      if (kp_bus.key_event === 1'b1) obs_events++;
      check_output("cycle");
   endtask

   task automatic frame(input bit hit, input logic [3:0] code);
      int gap = $urandom_range(0, 2);
      for (int i = 0; i < gap; i++) apply_stimulus(1'b0, 1'($urandom), 4'($urandom));
      apply_stimulus(1'b1, hit, code);
   endtask

   task automatic press(input logic [3:0] code);
      for (int i = 0; i < STABLE; i++) frame(1'b1, code);
      for (int i = 0; i < STABLE; i++) frame(1'b0, 4'h0);
   endtask

   initial begin
      int ev0;
      int len;
      logic [3:0] c;

      kp_bus.scan_valid = 1'b0;
      kp_bus.key_hit    = 1'b0;
      kp_bus.key_code   = 4'h0;
      clr_n = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_output("reset");
      end
      clr_n = 1'b1;

      $display("[TB] basic press/release");
      ev0 = obs_events;
      for (int i = 0; i < 6; i++) frame(1'b1, 4'h5);
      for (int i = 0; i < 4; i++) frame(1'b0, 4'h0);
      check_const("basic_events", 16'(obs_events - ev0), 16'd1);
      check_const("basic_digits", kp_bus.digits, 16'h0005);
      check_const("basic_count", 16'(kp_bus.digit_count), 16'd1);
      check_const("basic_held", 16'(kp_bus.key_held), 16'd0);

      $display("[TB] bounce rejection");
      ev0 = obs_events;
      frame(1'b1, 4'h3); frame(1'b1, 4'h3); frame(1'b0, 4'h0);
      for (int i = 0; i < 3; i++) frame(1'b1, 4'h3);
      check_const("bounce_early", 16'(obs_events - ev0), 16'd0);
      frame(1'b1, 4'h3);
      check_const("bounce_events", 16'(obs_events - ev0), 16'd1);
      for (int i = 0; i < 4; i++) frame(1'b0, 4'h0);

      $display("[TB] buffer entry and edits");
      for (int k = 1; k <= 5; k++) press(4'(k));
      check_const("buf_full", kp_bus.digits, 16'h2345);
      check_const("buf_full_cnt", 16'(kp_bus.digit_count), 16'd4);
      press(4'hE);
      check_const("buf_bksp", kp_bus.digits, 16'h0234);
      check_const("buf_bksp_cnt", 16'(kp_bus.digit_count), 16'd3);
      press(4'hF);
      check_const("buf_clear", kp_bus.digits, 16'h0000);
      press(4'hE);
      check_const("buf_bksp_empty", kp_bus.digits, 16'h0000);
      check_const("buf_bksp_empty_cnt", 16'(kp_bus.digit_count), 16'd0);

      $display("[TB] non-digit and rollover");
      press(4'hA);
      check_const("nondigit_out", 16'(kp_bus.key_out), 16'h000A);
      check_const("nondigit_digits", kp_bus.digits, 16'h0000);
      ev0 = obs_events;
      for (int i = 0; i < STABLE; i++) frame(1'b1, 4'h7);
      for (int i = 0; i < 10; i++) frame(1'b1, 4'h8);
      for (int i = 0; i < STABLE; i++) frame(1'b0, 4'h0);
      check_const("rollover_events", 16'(obs_events - ev0), 16'd1);
      check_const("rollover_digits", kp_bus.digits, 16'h0007);

      $display("[TB] reset mid-debounce");
      frame(1'b1, 4'h9); frame(1'b1, 4'h9);
      @(negedge clk);
      #2 clr_n = 1'b0;
      model_reset();
      #1 check_output("async_reset");
      kp_bus.scan_valid = 1'b1; kp_bus.key_hit = 1'b1; kp_bus.key_code = 4'h9;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check_output("in_reset");
      end
      kp_bus.scan_valid = 1'b0;
      clr_n = 1'b1;
      ev0 = obs_events;
      for (int i = 0; i < 3; i++) frame(1'b1, 4'h9);
      check_const("post_reset_early", 16'(obs_events - ev0), 16'd0);
      frame(1'b1, 4'h9);
      check_const("post_reset_event", 16'(obs_events - ev0), 16'd1);
      for (int i = 0; i < STABLE; i++) frame(1'b0, 4'h0);
      check_const("post_reset_digits", kp_bus.digits, 16'h0009);

      $display("[TB] long hold");
      press(4'hF);
      ev0 = obs_events;
      for (int i = 0; i < 13; i++) frame(1'b1, 4'h1);
      for (int i = 0; i < STABLE; i++) frame(1'b0, 4'h0);
`ifdef KEY_REPEAT_EN
      check_const("hold_events", 16'(obs_events - ev0), 16'd4);
      check_const("hold_digits", kp_bus.digits, 16'h1111);
`else
      check_const("hold_events", 16'(obs_events - ev0), 16'd1);
      check_const("hold_digits", kp_bus.digits, 16'h0001);
`endif

      $display("[TB] randomized frames");
      for (int s = 0; s < 60; s++) begin
         c   = 4'($urandom);
         len = $urandom_range(1, 12);
         for (int i = 0; i < len; i++) begin
            case ($urandom_range(0, 9))
               0:       frame(1'b0, 4'h0);
               1:       frame(1'b1, 4'($urandom));
               default: frame(1'b1, c);
            endcase
         end
         len = $urandom_range(1, 8);
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 7) == 0) frame(1'b1, 4'($urandom));
            else frame(1'b0, 4'h0);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
